router_vc_output_port: RTL
==========================

# router_vc_output_port

Parametrised output port for the mesh NoC router. It buffers flits from the crossbar into NUM_VC per-virtual-channel FIFOs of depth VC_DEPTH, and drives one registered flit per cycle onto the link when the downstream receiver is ready. VCs are served round-robin, and per-VC backpressure goes back to the input channels. It sits between the router crossbar and each of the N/S/E/W/local link drivers.

## Interface
- DATA_W, 64, flit width in bits
- NUM_VC, 2, number of virtual channels (power of two, ≥2)
- VC_DEPTH, 4, FIFO entries per VC (power of two, ≥2)
- VCW (localparam), $clog2(NUM_VC), VC index width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  flit present on in_data
- in_vc  in  VCW  target VC of incoming flit
- in_data  in  DATA_W  incoming flit
- blocked  out  NUM_VC  bit v high when VC v FIFO is full (combinational from count)
- polarity  in  1  global cycle polarity (used only under ROUTER_OVC_POLARITY_EN)
- out_ready  in  1  downstream receiver can accept a flit this cycle
- out_send  out  1  registered: out_data/out_vc valid this cycle
- out_vc  out  VCW  registered VC index of flit on out_data
- out_data  out  DATA_W  registered outgoing flit, zero when out_send low
- drop_err  out  1  sticky: a flit was presented to a full VC

## Operation
- Each VC has a circular FIFO: wr_ptr, rd_ptr (log2 VC_DEPTH bits, wrap modulo VC_DEPTH), count (log2 VC_DEPTH + 1 bits, 0..VC_DEPTH).
- Push: in_valid && !blocked[in_vc] writes in_data at wr_ptr[in_vc] and increments it.
- Full VC: in_valid && blocked[in_vc] leaves the FIFO unchanged and sets drop_err. drop_err clears only on reset.
- The blocked value is taken before any same-cycle pop. A full VC rejects a push even if it pops the same cycle.
- Eligible VC: count > 0.
- Arbitration: round-robin pointer rr_last (VCW bits). The search starts at (rr_last+1) mod NUM_VC and picks the first eligible VC.
- Pop: when out_ready and at least one VC is eligible, the selected head is popped, rd_ptr/count update, and rr_last is set to the selected VC.
- Pop and push to the same non-full VC in one cycle: count is unchanged and both pointers advance.
- Empty FIFO: no pop. out_send goes low the next cycle.
- No flit is ever duplicated or reordered within a VC.

## Timing
- Reset values:
  - out_send = 0, out_data = 0, out_vc = 0, drop_err = 0.
  - All counts = 0, all pointers = 0, rr_last = NUM_VC-1, so VC0 is served first.
  - blocked = 0.
- Reset mid-operation discards all buffered flits in the same edge.
- Latency: a flit pushed at edge k is eligible at edge k+1. It appears on out_data with out_send=1 after edge k+1 at the earliest, i.e. 1 cycle of buffering latency.
- Throughput: one flit per cycle sustained while out_ready is high and data is available.
- out_ready is sampled at the edge. out_send asserted in cycle t+1 means the flit was handed off in cycle t.
- Outputs are registered. When out_ready is low or no VC is eligible, the next cycle drives out_send=0 and out_data=0; no stall-hold of the previous flit.
- blocked[v] updates in the cycle after count reaches VC_DEPTH, or after count leaves it.

## Configuration
- ROUTER_OVC_POLARITY_EN defined:
  - Odd/even link discipline for the mesh; valid only with NUM_VC=2.
  - A push is accepted only when in_vc == polarity. A mismatched push is ignored and sets drop_err.
  - Only VC (~polarity) is eligible for output, so the VC being filled is never the VC being drained in the same cycle.
  - Round-robin is bypassed.
- Undefined: polarity is ignored, and any VC may be pushed and popped in any cycle under round-robin arbitration.

## Test plan
- Reset, then push 0xA1 to VC0 with out_ready=1 → next cycle out_send=1, out_vc=0, out_data=0xA1. Following cycle out_send=0, out_data=0.
- out_ready=0, push 4 flits to VC1 (VC_DEPTH=4) → blocked=2'b10. A fifth push sets drop_err=1 and does not overwrite stored data. Then out_ready=1 → the 4 flits leave in order on 4 consecutive cycles, and blocked clears the cycle after the first pop.
- Fill VC0 with 0x10,0x11 and VC1 with 0x20,0x21, then out_ready=1 → output order 0x10,0x20,0x11,0x21 with out_vc 0,1,0,1.
- Full VC0, same-cycle push+pop while out_ready=1 → push rejected, drop_err=1, count becomes 3. Separately, a partially filled VC with simultaneous push+pop keeps its count unchanged.
- Assert reset with 3 flits buffered → next cycle all outputs are zero and blocked=0. A flit pushed afterwards exits with nothing stale ahead of it.
- With ROUTER_OVC_POLARITY_EN: polarity=1, push to VC1 accepted; push to VC0 sets drop_err. Output is drawn only from VC0 while polarity=1, and from VC1 after polarity flips to 0.

Source files
------------

// File: rtl/router_vc_output_port.sv
// NoC router output port: NUM_VC circular FIFOs drained round-robin onto a registered link.
// Optional `ROUTER_OVC_POLARITY_EN: odd/even VC discipline selected by polarity (NUM_VC=2 only).
module router_vc_output_port #(
  parameter int DATA_W   = 64,
  parameter int NUM_VC   = 2,
  parameter int VC_DEPTH = 4,
  localparam int VCW     = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [VCW-1:0]    in_vc,
  input  logic [DATA_W-1:0] in_data,
  output logic [NUM_VC-1:0] blocked,
  input  logic              polarity,
  input  logic              out_ready,
  output logic              out_send,
  output logic [VCW-1:0]    out_vc,
  output logic [DATA_W-1:0] out_data,
  output logic              drop_err
);
  localparam int PW = $clog2(VC_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem    [NUM_VC][VC_DEPTH];
  logic [PW-1:0]     r_wr_ptr [NUM_VC];
  logic [PW-1:0]     r_rd_ptr [NUM_VC];
  logic [CW-1:0]     r_cnt    [NUM_VC];
  logic [VCW-1:0]    r_rr_last;

  logic              w_accept;
  logic              w_reject;
  logic              w_found;
  logic              w_pop;
  logic [VCW-1:0]    w_sel;
  logic [VCW-1:0]    w_cand;
  logic [NUM_VC-1:0] w_elig;
  logic [NUM_VC-1:0] w_push_v;
  logic [NUM_VC-1:0] w_pop_v;
  logic [DATA_W-1:0] w_head;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      blocked[v] = (r_cnt[v] == CW'(VC_DEPTH));
`ifdef ROUTER_OVC_POLARITY_EN
      // Only the VC opposite to the fill polarity may drain.
      w_elig[v]  = (r_cnt[v] != '0) && (VCW'(v) == VCW'(!polarity));
`else
      w_elig[v]  = (r_cnt[v] != '0);
`endif
    end
  end

`ifdef ROUTER_OVC_POLARITY_EN
  assign w_accept = in_valid && !blocked[in_vc] && (in_vc == VCW'(polarity));
`else
  logic w_unused_polarity;
  assign w_unused_polarity = polarity;
  assign w_accept = in_valid && !blocked[in_vc];
`endif
  assign w_reject = in_valid && !w_accept;

  // First eligible VC after the last one served; wraps naturally in VCW bits.
  always_comb begin
    w_sel   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_VC; i++) begin
      w_cand = r_rr_last + VCW'(i);
      if (!w_found && w_elig[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_pop  = out_ready && w_found;
  assign w_head = r_mem[w_sel][r_rd_ptr[w_sel]];

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_push_v[v] = w_accept && (in_vc == VCW'(v));
      w_pop_v[v]  = w_pop && (w_sel == VCW'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[in_vc][r_wr_ptr[in_vc]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_cnt[v]    <= '0;
      end
      r_rr_last <= VCW'(NUM_VC - 1);
      drop_err  <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_push_v[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PW'(1);
        if (w_pop_v[v])  r_rd_ptr[v] <= r_rd_ptr[v] + PW'(1);
        if (w_push_v[v] && !w_pop_v[v])      r_cnt[v] <= r_cnt[v] + CW'(1);
        else if (!w_push_v[v] && w_pop_v[v]) r_cnt[v] <= r_cnt[v] - CW'(1);
      end
      if (w_pop)    r_rr_last <= w_sel;
      if (w_reject) drop_err  <= 1'b1;
    end
  end

  // Link output stage: registered, zeroed whenever nothing is handed off.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_send <= 1'b0;
      out_vc   <= '0;
      out_data <= '0;
    end else begin
      out_send <= w_pop;
      out_vc   <= w_pop ? w_sel : '0;
      out_data <= w_pop ? w_head : '0;
    end
  end
endmodule
